// File: rtl/fix_tx_arb_pkg.sv
// Shared types and byte constants for the FIX transmit arbiter
// and its end-of-message detector.
package fix_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        STREAM
    } arb_state_t;

    typedef enum logic [2:0] {
        FLD_START,
        IN_FIELD,
        T1,
        T10,
        CK0,
        CK1,
        CK2,
        CK3
    } eom_state_t;

    localparam logic [7:0] SOH      = 8'h01;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_1  = 8'h31;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_EQ = 8'h3D;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/fix_tx_arbiter_eom.sv
// Tracks FIX field boundaries and recognises the "10=ddd<SOH>"
// checksum trailer that closes a message.
module fix_eom_detector
    import fix_tx_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       eom,
    output logic       fmt_err
);

    eom_state_t st;
    eom_state_t st_nxt;
    logic       soh;
    logic       dig;

    assign soh = data == SOH;
    assign dig = is_digit(data);

    always_comb begin
        st_nxt  = st;
        eom     = 1'b0;
        fmt_err = 1'b0;
        if (valid) begin
            unique case (st)
                FLD_START: st_nxt = (data == ASCII_1) ? T1 : IN_FIELD;
                T1:        st_nxt = (data == ASCII_0) ? T10 : IN_FIELD;
                T10:       st_nxt = (data == ASCII_EQ) ? CK0 : IN_FIELD;
                CK0, CK1, CK2: begin
                    if (!dig) begin
                        fmt_err = 1'b1;
                        st_nxt  = soh ? FLD_START : IN_FIELD;
                    end else if (st == CK0) begin
                        st_nxt = CK1;
                    end else if (st == CK1) begin
                        st_nxt = CK2;
                    end else begin
                        st_nxt = CK3;
                    end
                end
                CK3: begin
                    if (soh) begin
                        eom    = 1'b1;
                        st_nxt = FLD_START;
                    end else begin
                        fmt_err = 1'b1;
                        st_nxt  = IN_FIELD;
                    end
                end
                IN_FIELD: st_nxt = soh ? FLD_START : IN_FIELD;
                default:  st_nxt = FLD_START;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= FLD_START;
        end else if (clr) begin
            st <= FLD_START;
        end else begin
            st <= st_nxt;
        end
    end

endmodule

// File: rtl/fix_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one TOE transmit
// FIFO between several FIX engines.
module fix_tx_arbiter
    import fix_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   wr_i,
    input  logic [8*NUM_REQ-1:0] msg_i,
    output logic [NUM_REQ-1:0]   full_o,
    input  logic                 fifo_full_i,
    output logic                 fifo_write_o,
    output logic [7:0]           message_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 eom_o,
    output logic                 err_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    arb_state_t      state;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   pick;
    logic [TO_W-1:0] timer;
    logic            any_req;
    logic            hit_hi;
    logic            active;
    logic            acc;
    logic            det_eom;
    logic            det_err;
    logic            stray;
    logic            tmo;
    logic [7:0]      g_msg;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + IW'(1);
    endfunction

    assign active       = state != IDLE;
    assign g_msg        = msg_i[{gidx, 3'b000} +: 8];
    assign acc          = active & wr_i[gidx] & ~fifo_full_i;
    assign fifo_write_o = acc;
    assign message_o    = active ? g_msg : 8'h00;
    assign full_o       = {NUM_REQ{fifo_full_i}} | ~grant_o;
    assign stray        = |(wr_i & full_o);
    assign eom_o        = det_eom & (state == STREAM);
    assign tmo          = ~acc & ~fifo_full_i
                        & (timer == TO_W'(TIMEOUT - 1));

    // Downward scan leaves the lowest index at or after rr_ptr,
    // falling back to the lowest index below it.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        hit_hi  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                any_req = 1'b1;
                if (k >= int'(rr_ptr)) begin
                    pick   = IW'(k);
                    hit_hi = 1'b1;
                end else if (!hit_hi) begin
                    pick = IW'(k);
                end
            end
        end
    end

    fix_eom_detector u_eom (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == IDLE),
        .valid   (acc),
        .data    (g_msg),
        .eom     (det_eom),
        .fmt_err (det_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant_o <= '0;
            gidx    <= '0;
            rr_ptr  <= '0;
            timer   <= '0;
            err_o   <= 1'b0;
        end else begin
            if (stray || det_err) begin
                err_o <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    timer <= '0;
                    if (any_req) begin
                        state   <= GRANTED;
                        gidx    <= pick;
                        grant_o <= ONE << pick;
                    end
                end
                GRANTED, STREAM: begin
                    if (acc) begin
                        timer <= '0;
                    end else if (!fifo_full_i) begin
                        timer <= timer + TO_W'(1);
                    end
                    if (det_eom && state == STREAM) begin
                        state   <= IDLE;
                        grant_o <= '0;
                        rr_ptr  <= nxt(gidx);
                    end else if (acc) begin
                        state <= STREAM;
                    end else if (state == GRANTED && !req_i[gidx]) begin
                        state   <= IDLE;
                        grant_o <= '0;
                        rr_ptr  <= nxt(gidx);
                    end else if (tmo) begin
                        state   <= IDLE;
                        grant_o <= '0;
                        rr_ptr  <= nxt(gidx);
                        err_o   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fix_tx_arbiter.sv
// Randomised scoreboard bench for fix_tx_arbiter with a field-level
// FIX trailer model and a round-robin service-order model.
module tb_fix_tx_arbiter;

    localparam int N   = 2;
    localparam int TMO = 255;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_i = '0;
    logic [N-1:0]   wr_i = '0;
    logic [8*N-1:0] msg_i = '0;
    logic           fifo_full_i = 1'b0;
    logic [N-1:0]   full_o;
    logic           fifo_write_o;
    logic [7:0]     message_o;
    logic [N-1:0]   grant_o;
    logic           eom_o;
    logic           err_o;

    typedef struct {
        logic [7:0] b;
        bit         eom;
        int         eng;
    } sb_t;

    sb_t eng_q[N][$];
    sb_t sb_q[$];
    int  ord_q[$];
    int  m_cnt[N];
    int  m_ptr = 0;
    int  total = 0;
    int  bad = 0;
    bit  exp_err = 1'b0;
    bit  post_eom = 1'b0;

    fix_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO), .TO_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .wr_i         (wr_i),
        .msg_i        (msg_i),
        .full_o       (full_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_write_o (fifo_write_o),
        .message_o    (message_o),
        .grant_o      (grant_o),
        .eom_o        (eom_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit dig(input logic [7:0] c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    // Field-level view: a field "10=ddd" closes the message at its
    // SOH; any other field starting "10=" is a format error.
    function automatic void model_push(input int k, input string m);
        int    fs;
        bit    done;
        bit    e;
        logic [7:0] c;
        string f;
        fs   = 0;
        done = 1'b0;
        for (int i = 0; i < m.len() && !done; i++) begin
            c = m[i];
            e = 1'b0;
            if (c == 8'h7C) begin
                f = m.substr(fs, i - 1);
                if (f.len() >= 3 && f.substr(0, 2) == "10=") begin
                    if (f.len() == 6 && dig(f[3]) && dig(f[4]) && dig(f[5]))
                        e = 1'b1;
                    else
                        exp_err = 1'b1;
                end
                fs = i + 1;
                c  = 8'h01;
            end
            eng_q[k].push_back('{b: c, eom: e, eng: k});
            if (e) done = 1'b1;
        end
        m_cnt[k]++;
    endfunction

    function automatic string rand_msg(input bit bad_tr);
        string s;
        string t;
        int    nf;
        int    nv;
        s  = $sformatf("8=FIX.4.2|9=%0d|35=D|", $urandom_range(10, 99));
        nf = $urandom_range(1, 4);
        for (int f = 0; f < nf; f++) begin
            case ($urandom_range(0, 5))
                0:       t = "49";
                1:       t = "56";
                2:       t = "1";
                3:       t = "100";
                4:       t = "11";
                default: t = "52";
            endcase
            s  = {s, t, "="};
            nv = $urandom_range(1, 5);
            for (int j = 0; j < nv; j++)
                s = {s, $sformatf("%c", 8'(65 + $urandom_range(0, 25)))};
            s = {s, "|"};
        end
        if (bad_tr)
            s = {s, $sformatf("10=%0d%c|58=X|", $urandom_range(0, 99),
                              8'(65 + $urandom_range(0, 25)))};
        s = {s, $sformatf("10=%03d|", $urandom_range(0, 999))};
        return s;
    endfunction

    // All queued engines request from the start and keep requesting
    // while they have messages, so service is cyclic from the pointer.
    task automatic plan_order();
        int left;
        int e;
        left = m_cnt[0] + m_cnt[1];
        while (left > 0) begin
            for (int d = 0; d < N; d++) begin
                e = (m_ptr + d) % N;
                if (m_cnt[e] > 0) begin
                    ord_q.push_back(e);
                    m_cnt[e]--;
                    m_ptr = (e + 1) % N;
                    left--;
                    break;
                end
            end
        end
    endtask

    task automatic run_engines(input int stall_at, input bit rand_ff,
                               input bit stray, output int first_gnt);
        int cyc;
        int sent;
        int stall;
        bit stray_done;
        bit ff;
        cyc        = 0;
        sent       = 0;
        stall      = 0;
        stray_done = 1'b0;
        first_gnt  = -1;
        plan_order();
        while ((eng_q[0].size() + eng_q[1].size() + sb_q.size()) != 0
               && cyc < 4000) begin
            if (first_gnt < 0 && grant_o != '0) first_gnt = cyc;
            ff = 1'b0;
            if (stall > 0) begin
                ff = 1'b1;
                stall--;
            end else if (sent == stall_at) begin
                ff       = 1'b1;
                stall    = 9;
                stall_at = -1;
            end else if (rand_ff) begin
                ff = $urandom_range(0, 7) == 0;
            end
            fifo_full_i = ff;
            for (int k = 0; k < N; k++) begin
                req_i[k]         = eng_q[k].size() != 0;
                wr_i[k]          = 1'b0;
                msg_i[8*k +: 8]  = 8'($urandom);
                if (grant_o[k] && !ff && eng_q[k].size() != 0
                    && $urandom_range(0, 3) != 0) begin
                    wr_i[k]         = 1'b1;
                    msg_i[8*k +: 8] = eng_q[k][0].b;
                    sb_q.push_back(eng_q[k].pop_front());
                    sent++;
                end
            end
            if (stray && !stray_done && sent >= 3 && !grant_o[1]) begin
                wr_i[1]     = 1'b1;
                msg_i[15:8] = 8'hEE;
                stray_done  = 1'b1;
                exp_err     = 1'b1;
            end
            step();
            cyc++;
        end
        chk("run bound", 32'(cyc < 4000), 1);
        req_i       = '0;
        wr_i        = '0;
        fifo_full_i = 1'b0;
        repeat (2) step();
        chk("order drained", ord_q.size(), 0);
        for (int k = 0; k < N; k++) eng_q[k].delete();
        sb_q.delete();
        ord_q.delete();
    endtask

    task automatic do_reset();
        req_i       = '0;
        wr_i        = '0;
        fifo_full_i = 1'b0;
        #2;
        rst = 1'b0;
        step();
        rst     = 1'b1;
        m_ptr   = 0;
        exp_err = 1'b0;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
    endtask

    // Monitor: pops the scoreboard whenever the FIFO is written.
    initial begin
        sb_t          it;
        int           e;
        logic [N-1:0] oh;
        logic [N-1:0] xf;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (fifo_full_i) begin
                    chk("stall write", fifo_write_o, 0);
                    chk("stall full", full_o, 2'b11);
                end
                if (post_eom) begin
                    chk("bubble grant", grant_o, 0);
                    post_eom = 1'b0;
                end
                if (fifo_write_o) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected write", message_o, 9'h100);
                    end else begin
                        it = sb_q.pop_front();
                        oh = N'(1) << it.eng;
                        xf = ~oh;
                        chk("byte", message_o, it.b);
                        chk("eom", eom_o, it.eom);
                        chk("full", full_o, xf);
                        if (it.eom) begin
                            post_eom = 1'b1;
                            if (ord_q.size() == 0) begin
                                chk("order extra", 1, 0);
                            end else begin
                                e  = ord_q.pop_front();
                                oh = N'(1) << e;
                                chk("eom order", grant_o, oh);
                            end
                        end
                    end
                end else if (eom_o) begin
                    chk("eom no write", eom_o, 0);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fg;
        int n;
        int c;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
        rst = 1'b0;
        repeat (2) step();
        chk("rst grant", grant_o, 0);
        chk("rst full", full_o, 2'b11);
        chk("rst write", fifo_write_o, 0);
        chk("rst msg", message_o, 0);
        chk("rst eom", eom_o, 0);
        chk("rst err", err_o, 0);
        rst = 1'b1;
        step();

        model_push(0, "8=FIX.4.2|9=5|35=A|10=123|");
        run_engines(-1, 1'b0, 1'b0, fg);
        chk("grant latency", fg, 1);
        chk("err single", err_o, exp_err);

        for (int k = 0; k < N; k++)
            for (int j = 0; j < 2; j++) model_push(k, rand_msg(1'b0));
        run_engines(-1, 1'b1, 1'b0, fg);
        chk("err alternate", err_o, exp_err);

        model_push(0, rand_msg(1'b0));
        run_engines(8, 1'b0, 1'b0, fg);
        chk("err stall", err_o, exp_err);

        model_push(0, rand_msg(1'b0));
        run_engines(-1, 1'b0, 1'b1, fg);
        chk("err stray", err_o, exp_err);
        do_reset();
        chk("err cleared", err_o, 0);

        model_push(1, "8=FIX.4.2|9=12|35=0|10=1A|58=x|10=045|");
        run_engines(-1, 1'b1, 1'b0, fg);
        chk("err trailer", err_o, exp_err);
        do_reset();

        req_i = 2'b01;
        step();
        chk("tmo grant", grant_o, 2'b01);
        req_i = 2'b11;
        n = 0;
        while (n < 400 && grant_o != '0) begin
            step();
            n++;
        end
        chk("tmo cycles", n, TMO);
        chk("tmo err", err_o, 1);
        step();
        chk("tmo next grant", grant_o, 2'b10);
        req_i = 2'b00;
        step();
        chk("req drop", grant_o, 0);
        do_reset();
        chk("tmo err reset", err_o, 0);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N; k++) begin
                c = $urandom_range(0, 3);
                for (int j = 0; j < c; j++)
                    model_push(k, rand_msg($urandom_range(0, 3) == 0));
            end
            run_engines(-1, 1'b1, 1'b0, fg);
            chk("err random", err_o, exp_err);
            do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
